// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-side front end.
package wb_arbiter_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with pointers wrapping modulo DEPTH and an explicit count for full/empty.
// The head is valid the cycle after a push; the caller must not push when full.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdat;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Merges non-stallable pipeline writebacks and FIFO-buffered multi-cycle results onto one
// regfile write port (1-cycle registered), tracking pending multi-cycle destinations.
module wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 64
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     pipe_valid,
  input  logic [wb_arbiter_pkg::REG_ADDR_W-1:0]    pipe_rd,
  input  logic [XLEN-1:0]                          pipe_data,
  output logic                                     pipe_stall,
  input  logic                                     mc_issue,
  input  logic [wb_arbiter_pkg::REG_ADDR_W-1:0]    mc_issue_rd,
  input  logic                                     mc_valid,
  output logic                                     mc_ready,
  input  logic [wb_arbiter_pkg::REG_ADDR_W-1:0]    mc_rd,
  input  logic [XLEN-1:0]                          mc_data,
  output logic                                     we,
  output logic [wb_arbiter_pkg::REG_ADDR_W-1:0]    rd,
  output logic [XLEN-1:0]                          wd,
  output logic [wb_arbiter_pkg::NREGS-1:0]         pending
);

  import wb_arbiter_pkg::*;

  localparam int                FW    = REG_ADDR_W + XLEN;
  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]         fifo_head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  pipe_sel;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       wd_q, wd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stall_q, stall_d;
  logic [NREGS-1:0]      pend_q, pend_d;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdat  ({mc_rd, mc_data}),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign mc_ready  = !fifo_full;
  assign fifo_push = mc_valid && mc_ready;
  assign head_rd   = fifo_head[FW-1:XLEN];
  assign head_data = fifo_head[XLEN-1:0];

  // A pipe write to x0 is a no-op, so it must not block the FIFO.
  assign pipe_sel  = pipe_valid && (pipe_rd != '0);
  assign fifo_pop  = !pipe_sel && !fifo_empty;

  always_comb begin
    we_d = 1'b0;
    rd_d = rd_q;
    wd_d = wd_q;
    if (pipe_sel) begin
      we_d = 1'b1;
      rd_d = pipe_rd;
      wd_d = pipe_data;
    end else if (fifo_pop && (head_rd != '0)) begin
      we_d = 1'b1;
      rd_d = head_rd;
      wd_d = head_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fifo_empty || fifo_pop) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    stall_d = (cnt_q == LIMIT);
  end

  // Clear before set so a same-register issue in the popping cycle keeps the bit.
  always_comb begin
    pend_d = pend_q;
    if (fifo_pop) begin
      pend_d[head_rd] = 1'b0;
    end
    if (mc_issue) begin
      pend_d[mc_issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      rd_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      we_q    <= we_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      pend_q  <= pend_d;
    end
  end

  assign we         = we_q;
  assign rd         = rd_q;
  assign wd         = wd_q;
  assign pipe_stall = stall_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a reference model predicts each write into a scoreboard queue.
module tb_wb_arbiter;

  import wb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_data;
  logic        pipe_stall;
  logic        mc_issue;
  logic [4:0]  mc_issue_rd;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [63:0] mc_data;
  logic        we;
  logic [4:0]  rd;
  logic [63:0] wd;
  logic [31:0] pending;

  wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT),
    .XLEN         (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_valid  (pipe_valid),
    .pipe_rd     (pipe_rd),
    .pipe_data   (pipe_data),
    .pipe_stall  (pipe_stall),
    .mc_issue    (mc_issue),
    .mc_issue_rd (mc_issue_rd),
    .mc_valid    (mc_valid),
    .mc_ready    (mc_ready),
    .mc_rd       (mc_rd),
    .mc_data     (mc_data),
    .we          (we),
    .rd          (rd),
    .wd          (wd),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  wb_req_t     mq[$];
  wb_req_t     exp_q[$];
  int          m_cnt;
  logic        m_stall;
  logic [31:0] m_pend;
  logic [4:0]  m_rd;
  logic [63:0] m_wd;
  int          checks;
  int          failures;
  int          violations;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    reset       = 1'b0;
    pipe_valid  = 1'b0;
    pipe_rd     = '0;
    pipe_data   = '0;
    mc_issue    = 1'b0;
    mc_issue_rd = '0;
    mc_valid    = 1'b0;
    mc_rd       = '0;
    mc_data     = '0;
  endtask

  // One clock: predict, clock the DUT, advance the model, compare all outputs.
  task automatic step();
    wb_req_t e;
    wb_req_t h;
    bit psel, pop, rdy;
    e = '0;
    rdy = (mq.size() < DEPTH);
    chk("mc_ready", mc_ready, rdy);
    if (pipe_valid && m_stall) begin
      violations++;
      $display("protocol violation: pipe_valid asserted while pipe_stall=1 at %0t", $time);
    end
    psel = pipe_valid && (pipe_rd != 0);
    pop  = !psel && (mq.size() > 0);
    if (!reset) begin
      if (psel) begin
        e.valid = 1'b1; e.rd = pipe_rd; e.data = pipe_data;
      end else if (pop && (mq[0].rd != 0)) begin
        e.valid = 1'b1; e.rd = mq[0].rd; e.data = mq[0].data;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_cnt = 0; m_stall = 1'b0; m_pend = '0; m_rd = '0; m_wd = '0;
    end else begin
      m_stall = (m_cnt == LIMIT);
      if (mq.size() == 0 || pop) m_cnt = 0;
      else if (m_cnt < LIMIT) m_cnt++;
      if (pop) begin
        h = mq.pop_front();
        m_pend[h.rd] = 1'b0;
      end
      if (mc_valid && rdy) begin
        h.valid = 1'b1; h.rd = mc_rd; h.data = mc_data;
        mq.push_back(h);
      end
      if (mc_issue && (mc_issue_rd != 0)) m_pend[mc_issue_rd] = 1'b1;
      m_pend[0] = 1'b0;
    end
    #1;
    e = exp_q.pop_front();
    chk("we", we, e.valid);
    if (e.valid) begin
      m_rd = e.rd;
      m_wd = e.data;
    end
    chk("rd", rd, m_rd);
    chk("wd", wd, m_wd);
    chk("pending", pending, m_pend);
    chk("pipe_stall", pipe_stall, m_stall);
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; violations = 0;
    m_cnt = 0; m_stall = 1'b0; m_pend = '0; m_rd = '0; m_wd = '0;
    idle();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    step();
    chk("reset_we", we, 1'b0);
    chk("reset_ready", mc_ready, 1'b1);
    chk("reset_pending", pending, 32'h0);
    chk("reset_stall", pipe_stall, 1'b0);
    idle();
    step();

    // Pipe only
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 64'hDEAD;
    step();
    chk("t1_we", we, 1'b1);
    chk("t1_rd", rd, 5'd5);
    chk("t1_wd", wd, 64'hDEAD);
    idle();
    step();
    chk("t1_ready", mc_ready, 1'b1);

    // Multi-cycle only
    mc_issue = 1'b1; mc_issue_rd = 5'd7;
    step();
    chk("t2_pend_set", pending[7], 1'b1);
    idle();
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 64'h1234;
    step();
    chk("t2_no_early_we", we, 1'b0);
    idle();
    step();
    chk("t2_we", we, 1'b1);
    chk("t2_rd", rd, 5'd7);
    chk("t2_wd", wd, 64'h1234);
    chk("t2_pend_clr", pending[7], 1'b0);

    // Contention and starvation
    pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 64'h900;
    mc_valid = 1'b1; mc_rd = 5'd3; mc_data = 64'hAA;
    step();
    mc_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      pipe_data = 64'h900 + 64'(i);
      step();
      chk("t3_pipe_rd", rd, 5'd9);
      if (i == 4) chk("t3_stall_low", pipe_stall, 1'b0);
      if (i == 5) chk("t3_stall_high", pipe_stall, 1'b1);
    end
    idle();
    step();
    chk("t3_we", we, 1'b1);
    chk("t3_rd", rd, 5'd3);
    chk("t3_wd", wd, 64'hAA);
    step();
    chk("t3_stall_fall", pipe_stall, 1'b0);

    // Full FIFO with pipe busy
    pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 64'h999;
    mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 64'h1;
    step();
    mc_rd = 5'd11; mc_data = 64'h2;
    step();
    chk("t4_full_ready", mc_ready, 1'b0);
    mc_rd = 5'd12; mc_data = 64'h3;
    step();
    idle();
    step();
    chk("t4_drain1_rd", rd, 5'd10);
    chk("t4_drain1_wd", wd, 64'h1);
    step();
    chk("t4_drain2_rd", rd, 5'd11);
    chk("t4_drain2_wd", wd, 64'h2);
    chk("t4_ready_back", mc_ready, 1'b1);
    step();
    chk("t4_held_off", we, 1'b0);

    // Writes to x0
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 64'hBAD;
    mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 64'h55;
    mc_issue = 1'b1; mc_issue_rd = 5'd0;
    step();
    chk("t5_pend_x0", pending, 32'h0);
    mc_valid = 1'b0; mc_issue = 1'b0;
    step();
    chk("t5_we", we, 1'b1);
    chk("t5_rd", rd, 5'd4);
    chk("t5_wd", wd, 64'h55);
    idle();
    mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 64'h77;
    step();
    idle();
    step();
    chk("t5_pop_x0_we", we, 1'b0);
    chk("t5_pop_x0_rd_hold", rd, 5'd4);

    // Set/clear race on the same register
    mc_issue = 1'b1; mc_issue_rd = 5'd6;
    step();
    idle();
    mc_valid = 1'b1; mc_rd = 5'd6; mc_data = 64'h66;
    step();
    idle();
    mc_issue = 1'b1; mc_issue_rd = 5'd6;
    step();
    chk("t6_race_we", we, 1'b1);
    chk("t6_race_pend", pending[6], 1'b1);

    // Mid-operation reset with two queued entries
    mc_issue = 1'b1; mc_issue_rd = 5'd8;
    pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 64'h1;
    mc_valid = 1'b1; mc_rd = 5'd13; mc_data = 64'hD;
    step();
    mc_issue = 1'b0;
    mc_rd = 5'd14; mc_data = 64'hE;
    step();
    chk("t6_full_before_reset", mc_ready, 1'b0);
    idle();
    reset = 1'b1;
    step();
    chk("t6_reset_ready", mc_ready, 1'b1);
    chk("t6_reset_pending", pending, 32'h0);
    chk("t6_reset_we", we, 1'b0);
    idle();
    step();
    chk("t6_discarded_we", we, 1'b0);
    step();

    $display("protocol violations observed: %0d", violations);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
